// File: rtl/regfile_wb_pkg.sv
// Shared types for the register-file writeback arbiter.
// DATA_W / ADDR_W are the default write-port widths; wb_req_t is the entry
// stored in each source FIFO. The top's width parameters must match these.
package regfile_wb_pkg;
    localparam int DATA_W  = 32;
    localparam int ADDR_W  = 4;
    localparam int NUM_SRC = 2;

    typedef struct packed {
        logic [ADDR_W-1:0] addr;
        logic [DATA_W-1:0] data;
    } wb_req_t;
endpackage

// File: rtl/regfile_wb_arbiter_fifo.sv
// wb_fifo: synchronous FIFO of wb_req_t for one writeback source.
// Ports: clk, rst (sync, active high), push/push_data, pop, head,
//        full, empty, entry_valid (per slot), entry_addr (per slot address).
// Pointers carry one extra wrap bit so full and empty are distinguishable.
// The caller only pops when not empty; a push while full is dropped.
module wb_fifo
    import regfile_wb_pkg::*;
#(
    parameter int DEPTH = 2
) (
    input  logic                          clk,
    input  logic                          rst,
    input  logic                          push,
    input  wb_req_t                       push_data,
    input  logic                          pop,
    output wb_req_t                       head,
    output logic                          full,
    output logic                          empty,
    output logic [DEPTH-1:0]              entry_valid,
    output logic [DEPTH-1:0][ADDR_W-1:0]  entry_addr
);
    localparam int PTR_W = $clog2(DEPTH);

    wb_req_t          mem [DEPTH];
    logic [PTR_W:0]   wr_ptr;
    logic [PTR_W:0]   rd_ptr;
    logic [PTR_W:0]   count;
    logic             push_en;

    assign count   = wr_ptr - rd_ptr;
    assign empty   = (wr_ptr == rd_ptr);
    assign full    = (count == (PTR_W+1)'(DEPTH));
    assign push_en = push && !full;
    assign head    = mem[rd_ptr[PTR_W-1:0]];

    always_ff @(posedge clk) begin
        if (rst) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
        end else begin
            if (push_en) wr_ptr <= wr_ptr + 1'b1;
            if (pop)     rd_ptr <= rd_ptr + 1'b1;
        end
    end

    // Storage needs no reset: slots are only observed while marked valid.
    always_ff @(posedge clk) begin
        if (!rst && push_en) mem[wr_ptr[PTR_W-1:0]] <= push_data;
    end

    // A slot is live when its distance from the read pointer is below count.
    always_comb begin
        logic [PTR_W-1:0] offs;
        offs        = '0;
        entry_valid = '0;
        entry_addr  = '0;
        for (int k = 0; k < DEPTH; k++) begin
            offs           = PTR_W'(k) - rd_ptr[PTR_W-1:0];
            entry_valid[k] = ({1'b0, offs} < count);
            entry_addr[k]  = mem[k].addr;
        end
    end
endmodule

// File: rtl/regfile_wb_arbiter.sv
// regfile_wb_arbiter: shares the register file write port (we3/wa3/wd3)
// between the vector ALU (source 0) and the load unit (source 1).
// Ports: clk, rst (sync, active high), s_valid/s_ready/s_addr/s_data per
//        source (flat, source i at slice i), we3/wa3/wd3 registered write
//        stage, pending (one bit per register with a queued or staged write),
//        conflict_cnt (only when WB_CONFLICT_CNT_EN is defined).
// Round robin only advances on contention, so a lone source never moves it.
module regfile_wb_arbiter #(
    parameter int DATA_W     = regfile_wb_pkg::DATA_W,
    parameter int ADDR_W     = regfile_wb_pkg::ADDR_W,
    parameter int FIFO_DEPTH = 2
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic [1:0]            s_valid,
    output logic [1:0]            s_ready,
    input  logic [2*ADDR_W-1:0]   s_addr,
    input  logic [2*DATA_W-1:0]   s_data,
    output logic                  we3,
    output logic [ADDR_W-1:0]     wa3,
    output logic [DATA_W-1:0]     wd3,
    output logic [2**ADDR_W-1:0]  pending
`ifdef WB_CONFLICT_CNT_EN
   ,output logic [15:0]           conflict_cnt
`endif
);
    import regfile_wb_pkg::*;

    wb_req_t                             req   [NUM_SRC];
    wb_req_t                             head  [NUM_SRC];
    logic [FIFO_DEPTH-1:0]               ev    [NUM_SRC];
    logic [FIFO_DEPTH-1:0][ADDR_W-1:0]   ea    [NUM_SRC];
    logic [NUM_SRC-1:0]                  full;
    logic [NUM_SRC-1:0]                  empty;
    logic [NUM_SRC-1:0]                  pop;
    logic [NUM_SRC-1:0]                  head_valid;
    logic                                gnt_valid;
    logic                                gnt_idx;
    logic                                contended;
    logic                                rr_ptr;

    for (genvar i = 0; i < NUM_SRC; i++) begin : g_src
        assign req[i] = {s_addr[i*ADDR_W +: ADDR_W], s_data[i*DATA_W +: DATA_W]};

        wb_fifo #(.DEPTH(FIFO_DEPTH)) u_fifo (
            .clk         (clk),
            .rst         (rst),
            .push        (s_valid[i]),
            .push_data   (req[i]),
            .pop         (pop[i]),
            .head        (head[i]),
            .full        (full[i]),
            .empty       (empty[i]),
            .entry_valid (ev[i]),
            .entry_addr  (ea[i])
        );
    end

    assign s_ready    = ~full;
    assign head_valid = ~empty;

    always_comb begin
        gnt_valid = |head_valid;
        contended = &head_valid;
        gnt_idx   = 1'b0;
        if (contended)          gnt_idx = rr_ptr;
        else if (head_valid[1]) gnt_idx = 1'b1;
        pop = '0;
        if (gnt_valid) pop[gnt_idx] = 1'b1;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            rr_ptr <= 1'b0;
            we3    <= 1'b0;
            wa3    <= '0;
            wd3    <= '0;
        end else begin
            if (contended) rr_ptr <= ~gnt_idx;
            we3 <= gnt_valid;
            if (gnt_valid) begin
                wa3 <= head[gnt_idx].addr;
                wd3 <= head[gnt_idx].data;
            end
        end
    end

    always_comb begin
        pending = '0;
        for (int i = 0; i < NUM_SRC; i++) begin
            for (int k = 0; k < FIFO_DEPTH; k++) begin
                if (ev[i][k]) pending[ea[i][k]] = 1'b1;
            end
        end
        if (we3) pending[wa3] = 1'b1;
    end

`ifdef WB_CONFLICT_CNT_EN
    always_ff @(posedge clk) begin
        if (rst)                                    conflict_cnt <= '0;
        else if (contended && conflict_cnt != 16'hFFFF) conflict_cnt <= conflict_cnt + 1'b1;
    end
`endif
endmodule

// File: tb/tb_regfile_wb_arbiter.sv
module tb_regfile_wb_arbiter;
    localparam int AW    = 4;
    localparam int DW    = 32;
    localparam int DEPTH = 2;

    logic            clk = 1'b0;
    logic            rst;
    logic [1:0]      s_valid;
    logic [1:0]      s_ready;
    logic [2*AW-1:0] s_addr;
    logic [2*DW-1:0] s_data;
    logic            we3;
    logic [AW-1:0]   wa3;
    logic [DW-1:0]   wd3;
    logic [15:0]     pending;
`ifdef WB_CONFLICT_CNT_EN
    logic [15:0]     conflict_cnt;
`endif

    always #5 clk = ~clk;

    regfile_wb_arbiter dut (
        .clk     (clk),
        .rst     (rst),
        .s_valid (s_valid),
        .s_ready (s_ready),
        .s_addr  (s_addr),
        .s_data  (s_data),
        .we3     (we3),
        .wa3     (wa3),
        .wd3     (wd3),
        .pending (pending)
`ifdef WB_CONFLICT_CNT_EN
       ,.conflict_cnt (conflict_cnt)
`endif
    );

    // Reference model: per-source queues, a write stage, a contention preference.
    typedef struct packed {
        logic [AW-1:0] a;
        logic [DW-1:0] d;
    } ent_t;

    ent_t          mq [2][$];
    logic          m_we;
    logic [AW-1:0] m_wa;
    logic [DW-1:0] m_wd;
    int            m_pref;
    int            m_conf;
    logic [1:0]    m_acc;

    int n_total = 0;
    int n_pass  = 0;
    int n_fail  = 0;
    int n_wr    = 0;
    int n_acc   = 0;
    logic [DW-1:0] last_wd;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_total++;
        assert (obs === exp) n_pass++;
        else begin
            n_fail++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    function automatic logic [1:0] model_ready();
        logic [1:0] r;
        for (int i = 0; i < 2; i++) r[i] = (mq[i].size() < DEPTH);
        return r;
    endfunction

    function automatic logic [15:0] model_pending();
        logic [15:0] p;
        p = '0;
        for (int i = 0; i < 2; i++)
            for (int j = 0; j < mq[i].size(); j++) p[mq[i][j].a] = 1'b1;
        if (m_we) p[m_wa] = 1'b1;
        return p;
    endfunction

    task automatic model_clear();
        mq[0].delete();
        mq[1].delete();
        m_we = 1'b0; m_wa = '0; m_wd = '0;
        m_pref = 0; m_conf = 0; m_acc = '0;
    endtask

    // Compare the current outputs with the model, advance one clock, advance the model.
    task automatic step();
        int   g;
        ent_t e;
        chk("s_ready", 64'(s_ready), 64'(model_ready()));
        chk("we3", 64'(we3), 64'(m_we));
        chk("wa3", 64'(wa3), 64'(m_wa));
        chk("wd3", 64'(wd3), 64'(m_wd));
        chk("pending", 64'(pending), 64'(model_pending()));
`ifdef WB_CONFLICT_CNT_EN
        chk("conflict_cnt", 64'(conflict_cnt), 64'(m_conf));
`endif
        if (we3) begin
            n_wr++;
            last_wd = wd3;
        end
        m_acc = '0;
        if (rst) begin
            model_clear();
        end else begin
            for (int i = 0; i < 2; i++) m_acc[i] = s_valid[i] && (mq[i].size() < DEPTH);
            g = -1;
            if (mq[0].size() > 0 && mq[1].size() > 0) begin
                g      = m_pref;
                m_pref = 1 - g;
                if (m_conf < 65535) m_conf++;
            end else if (mq[0].size() > 0) g = 0;
            else if (mq[1].size() > 0)     g = 1;
            if (g >= 0) begin
                e    = mq[g].pop_front();
                m_we = 1'b1;
                m_wa = e.a;
                m_wd = e.d;
            end else begin
                m_we = 1'b0;
            end
            for (int i = 0; i < 2; i++) begin
                if (m_acc[i]) begin
                    e.a = s_addr[i*AW +: AW];
                    e.d = s_data[i*DW +: DW];
                    mq[i].push_back(e);
                    n_acc++;
                end
            end
        end
        @(posedge clk);
        #1;
    endtask

    task automatic put(input int i, input logic [AW-1:0] a, input logic [DW-1:0] d);
        s_valid[i]             = 1'b1;
        s_addr[i*AW +: AW]     = a;
        s_data[i*DW +: DW]     = d;
    endtask

    // Sources hold a refused request; after acceptance they draw a new one (run) or go idle.
    task automatic src_advance(input bit run, input int pct);
        for (int i = 0; i < 2; i++) begin
            if (m_acc[i] || !s_valid[i]) begin
                if (run) begin
                    s_valid[i]         = ($urandom_range(0, 99) < pct);
                    s_addr[i*AW +: AW] = AW'($urandom);
                    s_data[i*DW +: DW] = $urandom;
                end else begin
                    s_valid[i] = 1'b0;
                end
            end
        end
    endtask

    initial begin
        bit saw_full1;

        rst = 1'b1; s_valid = '0; s_addr = '0; s_data = '0;
        repeat (2) @(posedge clk);
        #1;
        model_clear();
        rst = 1'b0;
        chk("rst_we3", 64'(we3), 64'd0);
        chk("rst_pending", 64'(pending), 64'd0);
        chk("rst_s_ready", 64'(s_ready), 64'd3);
        chk("rst_wa3", 64'(wa3), 64'd0);

        // single push
        put(0, 4'd0, 32'd10);
        step();
        s_valid = '0;
        chk("t1_pend_queued", 64'(pending[0]), 64'd1);
        chk("t1_we3_early", 64'(we3), 64'd0);
        step();
        chk("t1_we3", 64'(we3), 64'd1);
        chk("t1_wa3", 64'(wa3), 64'd0);
        chk("t1_wd3", 64'(wd3), 64'd10);
        chk("t1_pend_stage", 64'(pending[0]), 64'd1);
        step();
        chk("t1_we3_drop", 64'(we3), 64'd0);
        chk("t1_pend_clear", 64'(pending), 64'd0);

        // simultaneous pushes, then repeat to see the round robin flip
        for (int r = 0; r < 2; r++) begin
            put(0, 4'd3, 32'hAA);
            put(1, 4'd5, 32'hBB);
            step();
            s_valid = '0;
            step();
            chk("t2_first_wa3", 64'(wa3), (r == 0) ? 64'd3 : 64'd5);
            chk("t2_first_wd3", 64'(wd3), (r == 0) ? 64'hAA : 64'hBB);
            step();
            chk("t2_second_we3", 64'(we3), 64'd1);
            chk("t2_second_wa3", 64'(wa3), (r == 0) ? 64'd5 : 64'd3);
            chk("t2_second_wd3", 64'(wd3), (r == 0) ? 64'hBB : 64'hAA);
            step();
        end

        // both sources saturating: FIFO1 must fill, nothing lost or duplicated
        n_wr = 0; n_acc = 0; saw_full1 = 1'b0;
        m_acc = '0;
        src_advance(1'b1, 100);
        for (int c = 0; c < 12; c++) begin
            if (s_ready[1] === 1'b0) saw_full1 = 1'b1;
            step();
            src_advance(1'b1, 100);
        end
        for (int c = 0; c < 20; c++) begin
            step();
            src_advance(1'b0, 0);
        end
        chk("t3_fifo1_filled", 64'(saw_full1), 64'd1);
        chk("t3_no_loss", 64'(n_wr), 64'(n_acc));

        // reset with entries queued
        put(0, 4'd9, 32'h11);
        put(1, 4'd12, 32'h22);
        step();
        s_valid = '0;
        rst = 1'b1;
        step();
        rst = 1'b0;
        chk("t4_we3", 64'(we3), 64'd0);
        chk("t4_pending", 64'(pending), 64'd0);
        chk("t4_s_ready", 64'(s_ready), 64'd3);
        n_wr = 0;
        repeat (3) step();
        chk("t4_no_stale", 64'(n_wr), 64'd0);

        // back-to-back writes to one register
        n_wr = 0;
        for (int v = 1; v <= 3; v++) begin
            put(0, 4'd7, 32'(v));
            step();
        end
        s_valid = '0;
        repeat (4) step();
        chk("t5_write_count", 64'(n_wr), 64'd3);
        chk("t5_final_wd3", 64'(last_wd), 64'd3);

        // randomized traffic with occasional resets
        m_acc = '0;
        src_advance(1'b1, 60);
        for (int c = 0; c < 300; c++) begin
            rst = ($urandom_range(0, 49) == 0);
            step();
            rst = 1'b0;
            src_advance(1'b1, 60);
        end
        for (int c = 0; c < 20; c++) begin
            step();
            src_advance(1'b0, 0);
        end

`ifdef WB_CONFLICT_CNT_EN
        rst = 1'b1;
        step();
        rst = 1'b0;
        for (int r = 0; r < 4; r++) begin
            put(0, AW'(r), 32'(r));
            put(1, AW'(r + 8), 32'(r + 100));
            step();
            s_valid = '0;
            repeat (2) step();
        end
        chk("t6_conflict_cnt", 64'(conflict_cnt), 64'd4);
        rst = 1'b1;
        step();
        rst = 1'b0;
        chk("t6_conflict_clr", 64'(conflict_cnt), 64'd0);
`endif

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end
endmodule
